slave_split_port: RTL and testbench
===================================

# slave_split_port

Slave-side handshake engine for one split line of the bus controller's `slaves` bus. It pulls the line low to announce a split (slave BUSY), releases it when the slave core has data ready (slave DONE), then waits for the controller's one-cycle low acknowledge. That acknowledge means the original master has been re-granted, and the port signals the core to resume. One instance sits between each slave core and its `slaves[i]` wire.

## Interface
- `MIN_BUSY`, 2: minimum cycles the line is held low (≥2, so the controller's BUSY_SLAVE_1/2 sequence completes)
- `GUARD`, 1: cycles after release during which the line is not sampled for acknowledge
- `ACK_TIMEOUT`, 1024: maximum WAIT_ACK cycles (used only with the macro)
- `COOLDOWN`, 2: cycles after resume before a new split is accepted
- `clk`  in  1  clock, rising edge
- `rstn`  in  1  reset, synchronous, active-high (1 = reset)
- `split_line`  inout  1  open-drain split wire; driven 0 or z, never driven 1; external pull-up
- `split_req`  in  1  core requests a split; sampled only in IDLE
- `split_done`  in  1  core data ready; level or pulse, latched in BUSY
- `split_busy`  out  1  high in BUSY, DONE_WAIT, WAIT_ACK
- `resume`  out  1  one-cycle pulse; original master is back on the bus
- `ack_timeout`  out  1  sticky acknowledge-timeout flag
- `state`  out  3  current state encoding

## Operation
- States: IDLE=0, BUSY=1, DONE_WAIT=2, WAIT_ACK=3, RESUME=4, COOLDOWN=5. Codes 6–7 are illegal and go to IDLE next cycle.
- IDLE: line released. `split_req`=1 → BUSY. Also sets `drive_low`, clears `cnt`, clears `ack_timeout`, and latches `done_l` = `split_done`.
- BUSY: line driven 0. `cnt` increments, saturating at `MIN_BUSY-1`. `done_l` |= `split_done`. Exit to DONE_WAIT when `cnt`==`MIN_BUSY-1` and (`done_l` or `split_done`). On exit, clear `drive_low` and `cnt`.
- DONE_WAIT: line released. Count `GUARD` cycles, ignoring the line, then go to WAIT_ACK with `cnt` cleared.
- WAIT_ACK: a sampled `split_line`==0 → RESUME. With the macro, `cnt` reaching `ACK_TIMEOUT-1` → IDLE and sets `ack_timeout`.
- RESUME: `resume`=1 for exactly this cycle → COOLDOWN.
- COOLDOWN: count `COOLDOWN` cycles → IDLE. `split_req` is ignored and not queued.
- `split_line` = `drive_low` ? 0 : z. `drive_low` is a register with no combinational path from inputs.
- `cnt` width is `$clog2` of the largest of the parameters used, plus 1.
- `split_done` outside BUSY has no effect.
- `split_req` outside IDLE has no effect.

## Timing
- Reset values:
  - state=IDLE, `split_line`=z
  - `split_busy`=0, `resume`=0, `ack_timeout`=0
  - `cnt`=0, `done_l`=0
- Reset mid-operation releases the line on the same edge. No `resume` pulse is issued.
- `split_req` sampled at edge N → line low from edge N through edge N+`MIN_BUSY` at minimum. The controller sees BUSY on its next sample.
- `split_done` and `split_req` high together in IDLE → line low exactly `MIN_BUSY` cycles.
- `split_done` arriving at BUSY cycle k ≥ `MIN_BUSY-1` → line released at the following edge. That is one cycle of latency.
- Acknowledge low sampled at edge M → `resume` high during cycle M..M+1. It is never high for more than one cycle, even if the line stays low.
- Earliest next split: `resume` edge + 1 + `COOLDOWN`.
- The line is low during DONE_WAIT guard → ignored. If it is still low at the first WAIT_ACK sample, it is treated as the acknowledge.

## Configuration
- `SPLIT_ACK_TIMEOUT_EN` defined:
  - The WAIT_ACK watchdog is compiled in.
  - On timeout, the port abandons the split, returns to IDLE with the line released, and sets `ack_timeout` until the next accepted `split_req` or reset.
- Not defined:
  - WAIT_ACK waits indefinitely.
  - `ack_timeout` is tied to 0 and the `ACK_TIMEOUT` counter logic is absent.

## Test plan
- Basic split: `split_req` pulse at cycle 10, `split_done` at cycle 20, acknowledge line low for 1 cycle at cycle 30 → line low cycles 11–21, `resume`=1 at cycle 31 only, `split_busy` falls at cycle 31.
- Early done: `split_req` and `split_done` together, `MIN_BUSY`=2 → line low exactly 2 cycles, then released.
- Guard, `GUARD`=1: line forced low on the first cycle after release, then high → no `resume`. A later 1-cycle low → exactly one `resume`.
- Cooldown, `COOLDOWN`=2: `split_req` held high continuously → the next BUSY entry occurs 3 cycles after the `resume` pulse.
- Reset: `rstn`=1 during BUSY → line z on the next cycle, state=0, all outputs 0. A later acknowledge pulse produces no `resume`.
- Watchdog (macro on, `ACK_TIMEOUT`=16): no acknowledge → state IDLE and `ack_timeout`=1 after 16 WAIT_ACK cycles. The next `split_req` clears the flag.

Source files
------------

// File: rtl/slave_split_port_if.sv
// slave_split_port_if: core-side handshake bundle for one split port.
// Ports (modport slave = the port, modport master = the slave core):
//   split_req   core -> port  request a split, sampled only in IDLE
//   split_done  core -> port  data ready, level or pulse, latched in BUSY
//   split_busy  port -> core  high while the split is outstanding
//   resume      port -> core  one-cycle pulse, original master is back
//   ack_timeout port -> core  sticky acknowledge-timeout flag
//   state       port -> core  current state encoding
interface slave_split_port_if;
    logic       split_req;
    logic       split_done;
    logic       split_busy;
    logic       resume;
    logic       ack_timeout;
    logic [2:0] state;
    modport master (
        output split_req, split_done,
        input  split_busy, resume, ack_timeout, state
    );
    modport slave (
        input  split_req, split_done,
        output split_busy, resume, ack_timeout, state
    );
endinterface

// File: rtl/slave_split_port.sv
// slave_split_port: slave-side split handshake engine for one open-drain split line.
// Pulls the line low while the core is busy, releases it when data is ready,
// waits for the controller's low acknowledge and pulses resume to the core.
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous reset, active high (1 = reset)
//   split_line open-drain split wire, driven 0 or z only, external pull-up
//   bus        slave_split_port_if.slave handshake bundle
// Optional feature: define SPLIT_ACK_TIMEOUT_EN to compile in the WAIT_ACK
// watchdog; otherwise WAIT_ACK waits forever and ack_timeout is tied to 0.
module slave_split_port #(
    parameter int MIN_BUSY    = 2,
    parameter int GUARD       = 1,
    parameter int ACK_TIMEOUT = 1024,
    parameter int COOLDOWN    = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    inout  wire                   split_line,
    slave_split_port_if.slave     bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_BUSY      = 3'd1,
        S_DONE_WAIT = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_RESUME    = 3'd4,
        S_COOL      = 3'd5
    } state_t;

    localparam int P0   = (MIN_BUSY > GUARD) ? MIN_BUSY : GUARD;
    localparam int P1   = (P0 > COOLDOWN) ? P0 : COOLDOWN;
    localparam int PMAX = (P1 > ACK_TIMEOUT) ? P1 : ACK_TIMEOUT;
    localparam int CW   = $clog2(PMAX) + 1;

    localparam logic [CW-1:0] BUSY_LAST  = CW'((MIN_BUSY > 0) ? MIN_BUSY - 1 : 0);
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);
    // The RESUME cycle is the first cooldown cycle, so COOLDOWN itself lasts one less.
    localparam logic [CW-1:0] COOL_LAST  = CW'((COOLDOWN > 2) ? COOLDOWN - 2 : 0);
`ifdef SPLIT_ACK_TIMEOUT_EN
    localparam logic [CW-1:0] ACK_LAST   = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
`endif

    state_t          r_state;
    logic            r_drive_low;
    logic [CW-1:0]   r_cnt;
    logic            r_done_l;
    logic            r_busy;
    logic            r_resume;
    logic            w_ack;
`ifdef SPLIT_ACK_TIMEOUT_EN
    logic            r_ack_timeout;
`endif

    // Open drain: only ever pull low, the pull-up supplies the high level.
    assign split_line = r_drive_low ? 1'b0 : 1'bz;
    assign w_ack      = ~split_line;

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state     <= S_IDLE;
            r_drive_low <= 1'b0;
            r_cnt       <= '0;
            r_done_l    <= 1'b0;
            r_busy      <= 1'b0;
            r_resume    <= 1'b0;
`ifdef SPLIT_ACK_TIMEOUT_EN
            r_ack_timeout <= 1'b0;
`endif
        end else begin
            r_resume <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.split_req) begin
                        r_state     <= S_BUSY;
                        r_drive_low <= 1'b1;
                        r_cnt       <= '0;
                        r_done_l    <= bus.split_done;
                        r_busy      <= 1'b1;
`ifdef SPLIT_ACK_TIMEOUT_EN
                        r_ack_timeout <= 1'b0;
`endif
                    end
                end
                S_BUSY: begin
                    r_done_l <= r_done_l | bus.split_done;
                    // Hold the line for the minimum time, then release as soon as data is ready.
                    if (r_cnt == BUSY_LAST && (r_done_l || bus.split_done)) begin
                        r_state     <= S_DONE_WAIT;
                        r_drive_low <= 1'b0;
                        r_cnt       <= '0;
                    end else if (r_cnt != BUSY_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE_WAIT: begin
                    // Line is not sampled here; it may still be settling after release.
                    if (r_cnt == GUARD_LAST) begin
                        r_state <= S_WAIT_ACK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (w_ack) begin
                        r_state  <= S_RESUME;
                        r_busy   <= 1'b0;
                        r_resume <= 1'b1;
`ifdef SPLIT_ACK_TIMEOUT_EN
                    end else if (r_cnt == ACK_LAST) begin
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                        r_ack_timeout <= 1'b1;
                        r_cnt         <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                S_RESUME: begin
                    r_state <= (COOLDOWN > 1) ? S_COOL : S_IDLE;
                    r_cnt   <= '0;
                end
                S_COOL: begin
                    if (r_cnt == COOL_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_drive_low <= 1'b0;
                    r_cnt       <= '0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.split_busy = r_busy;
    assign bus.resume     = r_resume;
    assign bus.state      = r_state;
`ifdef SPLIT_ACK_TIMEOUT_EN
    assign bus.ack_timeout = r_ack_timeout;
`else
    assign bus.ack_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_slave_split_port.sv
// tb_slave_split_port: randomized self-checking bench for slave_split_port.
module tb_slave_split_port;
    localparam int MIN_BUSY    = 2;
    localparam int GUARD       = 1;
    localparam int ACK_TIMEOUT = 16;
    localparam int COOLDOWN    = 2;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic r_pull = 1'b0;
    wire  split_line;
    int   errors = 0;
    int   checks = 0;

    slave_split_port_if bus();

    pullup (split_line);
    assign split_line = r_pull ? 1'b0 : 1'bz;

    slave_split_port #(
        .MIN_BUSY(MIN_BUSY), .GUARD(GUARD), .ACK_TIMEOUT(ACK_TIMEOUT), .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk), .rstn(rstn), .split_line(split_line), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, output int n);
        n = -1;
        for (int i = 0; i < 200; i++) begin
            if (bus.state === s) begin
                n = i;
                break;
            end
            step();
        end
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        bus.split_req = 1'b0;
        bus.split_done = 1'b0;
        r_pull = 1'b0;
        repeat (2) step();
        rstn = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        checks++; if (bus.split_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.split_busy); end
        checks++; if (bus.resume !== 1'b0) begin errors++; $display("FAIL reset_resume: got %b want 0", bus.resume); end
        checks++; if (bus.ack_timeout !== 1'b0) begin errors++; $display("FAIL reset_ack_timeout: got %b want 0", bus.ack_timeout); end
        checks++; if (split_line !== 1'b1) begin errors++; $display("FAIL reset_line: got %b want 1 (released)", split_line); end
        step();
        checks++; if (bus.state !== 3'd0 || split_line !== 1'b1) begin errors++; $display("FAIL idle_hold: state %0d line %b want 0/1", bus.state, split_line); end
    endtask

    // Random done delay and ack delay; expected BUSY length is max(MIN_BUSY, delay+1).
    task automatic test_basic();
        int d, a, low, exp_low, extra;
        for (int it = 0; it < 8; it++) begin
            d = $urandom_range(0, 6);
            a = $urandom_range(0, 4);
            bus.split_req = 1'b1;
            step();
            bus.split_req = 1'b0;
            checks++; if (bus.state !== 3'd1 || bus.split_busy !== 1'b1 || split_line !== 1'b0)
                begin errors++; $display("FAIL basic_enter: state %0d busy %b line %b want 1/1/0", bus.state, bus.split_busy, split_line); end
            low = 1;
            for (int i = 0; i < 64; i++) begin
                bus.split_done = (i == d);
                step();
                bus.split_done = 1'b0;
                if (split_line === 1'b0) low++; else break;
            end
            exp_low = (MIN_BUSY > d + 1) ? MIN_BUSY : d + 1;
            checks++; if (low != exp_low) begin errors++; $display("FAIL basic_low_len: got %0d want %0d (d=%0d)", low, exp_low, d); end
            checks++; if (bus.state !== 3'd2 || bus.split_busy !== 1'b1)
                begin errors++; $display("FAIL basic_done_wait: state %0d busy %b want 2/1", bus.state, bus.split_busy); end
            repeat (GUARD) step();
            checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL basic_wait_ack: got %0d want 3", bus.state); end
            for (int i = 0; i < a; i++) begin
                bus.split_done = 1'($urandom_range(0, 1));
                bus.split_req = 1'($urandom_range(0, 1));
                step();
                checks++; if (bus.resume !== 1'b0 || bus.state !== 3'd3 || bus.split_busy !== 1'b1)
                    begin errors++; $display("FAIL basic_waiting: resume %b state %0d busy %b want 0/3/1", bus.resume, bus.state, bus.split_busy); end
            end
            bus.split_done = 1'b0;
            bus.split_req = 1'b0;
            r_pull = 1'b1;
            step();
            checks++; if (bus.resume !== 1'b1 || bus.split_busy !== 1'b0 || bus.state !== 3'd4)
                begin errors++; $display("FAIL basic_resume: resume %b busy %b state %0d want 1/0/4", bus.resume, bus.split_busy, bus.state); end
            extra = 0;
            for (int i = 0; i < COOLDOWN + 2; i++) begin
                if (i == 0 && (it % 2) == 1) r_pull = 1'b1; else r_pull = 1'b0;
                step();
                if (bus.resume === 1'b1) extra++;
            end
            r_pull = 1'b0;
            checks++; if (extra != 0) begin errors++; $display("FAIL basic_resume_once: got %0d extra pulses want 0", extra); end
            checks++; if (bus.state !== 3'd0 || split_line !== 1'b1)
                begin errors++; $display("FAIL basic_back_idle: state %0d line %b want 0/1", bus.state, split_line); end
        end
    endtask

    task automatic test_early_done();
        int low, n;
        bus.split_req = 1'b1;
        bus.split_done = 1'b1;
        step();
        bus.split_req = 1'b0;
        bus.split_done = 1'b0;
        low = 0;
        for (int i = 0; i < 32; i++) begin
            if (split_line === 1'b0) low++; else break;
            step();
        end
        checks++; if (low != MIN_BUSY) begin errors++; $display("FAIL early_done_len: got %0d want %0d", low, MIN_BUSY); end
        wait_state(3'd3, n);
        r_pull = 1'b1; step(); r_pull = 1'b0;
        wait_state(3'd0, n);
        checks++; if (n < 0) begin errors++; $display("FAIL early_done_idle: timeout want state 0"); end
    endtask

    task automatic test_guard();
        int n, pulses;
        bus.split_req = 1'b1;
        bus.split_done = 1'b1;
        step();
        bus.split_req = 1'b0;
        bus.split_done = 1'b0;
        wait_state(3'd2, n);
        r_pull = 1'b1;
        repeat (GUARD) step();
        r_pull = 1'b0;
        checks++; if (bus.state !== 3'd3 || bus.resume !== 1'b0)
            begin errors++; $display("FAIL guard_ignored: state %0d resume %b want 3/0", bus.state, bus.resume); end
        pulses = 0;
        repeat (3) begin step(); if (bus.resume === 1'b1) pulses++; end
        checks++; if (pulses != 0) begin errors++; $display("FAIL guard_no_resume: got %0d pulses want 0", pulses); end
        r_pull = 1'b1; step(); r_pull = 1'b0;
        if (bus.resume === 1'b1) pulses++;
        repeat (4) begin step(); if (bus.resume === 1'b1) pulses++; end
        checks++; if (pulses != 1) begin errors++; $display("FAIL guard_one_resume: got %0d pulses want 1", pulses); end
    endtask

    task automatic test_cooldown();
        int n;
        bus.split_req = 1'b1;
        bus.split_done = 1'b1;
        step();
        bus.split_done = 1'b0;
        wait_state(3'd3, n);
        r_pull = 1'b1; step(); r_pull = 1'b0;
        checks++; if (bus.resume !== 1'b1) begin errors++; $display("FAIL cooldown_resume: got %b want 1", bus.resume); end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (bus.state === 3'd1) break;
        end
        checks++; if (n != 1 + COOLDOWN || bus.state !== 3'd1)
            begin errors++; $display("FAIL cooldown_rebusy: got %0d cycles state %0d want %0d/1", n, bus.state, 1 + COOLDOWN); end
        bus.split_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int pulses;
        do_reset();
        bus.split_req = 1'b1; step(); bus.split_req = 1'b0;
        rstn = 1'b1; step(); rstn = 1'b0;
        checks++; if (split_line !== 1'b1 || bus.state !== 3'd0 || bus.split_busy !== 1'b0 || bus.resume !== 1'b0 || bus.ack_timeout !== 1'b0)
            begin errors++; $display("FAIL reset_mid: line %b state %0d busy %b resume %b ato %b want 1/0/0/0/0", split_line, bus.state, bus.split_busy, bus.resume, bus.ack_timeout); end
        r_pull = 1'b1; step(); r_pull = 1'b0;
        pulses = (bus.resume === 1'b1) ? 1 : 0;
        repeat (3) begin step(); if (bus.resume === 1'b1) pulses++; end
        checks++; if (pulses != 0 || bus.state !== 3'd0)
            begin errors++; $display("FAIL reset_mid_no_resume: pulses %0d state %0d want 0/0", pulses, bus.state); end
    endtask

    task automatic test_watchdog();
        int n, cnt;
        bus.split_req = 1'b1; bus.split_done = 1'b1; step();
        bus.split_req = 1'b0; bus.split_done = 1'b0;
        wait_state(3'd3, n);
        checks++; if (n < 0) begin errors++; $display("FAIL wd_reach_wait: timeout want state 3"); end
`ifdef SPLIT_ACK_TIMEOUT_EN
        cnt = 0;
        while (bus.state === 3'd3 && cnt < 100) begin cnt++; step(); end
        checks++; if (cnt != ACK_TIMEOUT) begin errors++; $display("FAIL wd_cycles: got %0d want %0d", cnt, ACK_TIMEOUT); end
        checks++; if (bus.state !== 3'd0 || bus.ack_timeout !== 1'b1 || split_line !== 1'b1 || bus.split_busy !== 1'b0)
            begin errors++; $display("FAIL wd_abandon: state %0d ato %b line %b busy %b want 0/1/1/0", bus.state, bus.ack_timeout, split_line, bus.split_busy); end
        step();
        checks++; if (bus.ack_timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b want 1", bus.ack_timeout); end
        bus.split_req = 1'b1; step(); bus.split_req = 1'b0;
        checks++; if (bus.ack_timeout !== 1'b0 || bus.state !== 3'd1)
            begin errors++; $display("FAIL wd_clear: ato %b state %0d want 0/1", bus.ack_timeout, bus.state); end
`else
        cnt = 0;
        repeat (ACK_TIMEOUT + 8) step();
        checks++; if (bus.state !== 3'd3 || bus.ack_timeout !== 1'b0)
            begin errors++; $display("FAIL wd_absent: state %0d ato %b want 3/0", bus.state, bus.ack_timeout); end
        r_pull = 1'b1; step(); r_pull = 1'b0;
        checks++; if (bus.resume !== 1'b1) begin errors++; $display("FAIL wd_late_ack: resume %b want 1", bus.resume); end
`endif
        do_reset();
    endtask

    initial begin
        bus.split_req = 1'b0;
        bus.split_done = 1'b0;
        test_reset();
        test_basic();
        test_early_done();
        test_guard();
        test_cooldown();
        test_reset_mid();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
